// File: rtl/tisaradc_capture_rx_if.sv
// Stream interface carrying captured frames from tisaradc_capture_rx to the
// digital back-end.
//   out_valid : head frame available          (master -> slave)
//   out_ready : consumer accepts head frame   (slave  -> master)
//   out_data  : head frame, WAYS lanes of BITS (master -> slave)
//   out_sync  : head frame starts a contiguous run (master -> slave)
interface tisaradc_capture_rx_if #(
    parameter int WAYS = 8,
    parameter int BITS = 9
);
    logic                 out_valid;
    logic                 out_ready;
    logic [WAYS*BITS-1:0] out_data;
    logic                 out_sync;

    modport master (
        output out_valid,
        output out_data,
        output out_sync,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sync,
        output out_ready
    );
endinterface

// File: rtl/tisaradc_capture_rx.sv
// Receive-side capture for the time-interleaved SAR ADC, in the clkout_des domain.
// Registers one frame of WAYS sub-ADC words per cycle, optionally converts them to
// two's complement, and queues them in a show-ahead FIFO feeding a ready/valid stream.
// Frames arriving while the FIFO is full are dropped and counted.
//
// Optional feature macro: TISARADC_CAPTURE_TWOS_EN (offset binary -> two's complement
// by inverting each lane MSB; latency unchanged).
//
// Ports:
//   clk          : ADC deserialized clock
//   rst_n        : asynchronous active-low reset
//   adc_in       : input frame, lane i at [i*BITS +: BITS], lane 0 earliest
//   en           : capture enable
//   clear        : synchronous clear of overflow status
//   stream       : output stream (out_valid/out_ready/out_data/out_sync)
//   running      : FSM is in RUN
//   overflow     : sticky drop flag
//   overflow_cnt : dropped-frame count, saturating
module tisaradc_capture_rx #(
    parameter int WAYS         = 8,
    parameter int BITS         = 9,
    parameter int DEPTH        = 4,
    parameter int FLUSH_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAYS*BITS-1:0]  adc_in,
    input  logic                  en,
    input  logic                  clear,
    tisaradc_capture_rx_if.master stream,
    output logic                  running,
    output logic                  overflow,
    output logic [15:0]           overflow_cnt
);
    localparam int W  = WAYS * BITS;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (FLUSH_FRAMES > 1) ? $clog2(FLUSH_FRAMES) : 1;

    typedef enum logic [1:0] {StIdle, StFlush, StRun} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

    logic [W-1:0]    s1_data_q;
    logic            s1_vld_q;
    logic [W-1:0]    wdata;

    logic [W-1:0]    mem      [DEPTH];
    logic            sync_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d, count_after_pop;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_sync_q, out_sync_d;
    logic            pend_sync_q, pend_sync_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     ovf_cnt_q, ovf_cnt_d;

    logic            pop, push, drop, full;

    // FSM next state
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (flush_cnt_q == CW'(FLUSH_FRAMES - 1)) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!en) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 2 lane conversion
    always_comb begin
        wdata = s1_data_q;
`ifdef TISARADC_CAPTURE_TWOS_EN
        for (int i = 0; i < WAYS; i++) begin
            wdata[i*BITS + BITS - 1] = ~s1_data_q[i*BITS + BITS - 1];
        end
`endif
    end

    // FIFO control; a read in the same cycle frees the slot for a write when full
    always_comb begin
        full            = (count_q == (PW+1)'(DEPTH));
        pop             = out_valid_q && stream.out_ready;
        push            = s1_vld_q && (!full || pop);
        drop            = s1_vld_q && full && !pop;
        count_after_pop = count_q - (PW+1)'(pop);
        count_d         = count_after_pop + (PW+1)'(push);
        rd_ptr_d        = rd_ptr_q + PW'(pop);
        wr_ptr_d        = wr_ptr_q + PW'(push);

        // Output register reloads with the next head; an empty FIFO forwards the write
        out_valid_d = (count_d != '0);
        out_data_d  = out_data_q;
        out_sync_d  = out_sync_q;
        if (count_d != '0) begin
            if (count_after_pop == '0) begin
                out_data_d = wdata;
                out_sync_d = pend_sync_q;
            end else begin
                out_data_d = mem[rd_ptr_d];
                out_sync_d = sync_mem[rd_ptr_d];
            end
        end

        // Setting takes priority over clearing on the same cycle
        pend_sync_d = pend_sync_q;
        if (push) pend_sync_d = 1'b0;
        if (state_q != StRun && state_d == StRun) pend_sync_d = 1'b1;
        if (drop) pend_sync_d = 1'b1;

        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (clear) begin
            overflow_d = drop;
            ovf_cnt_d  = {15'd0, drop};
        end else if (drop) begin
            overflow_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            s1_data_q   <= '0;
            s1_vld_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sync_q  <= 1'b0;
            pend_sync_q <= 1'b0;
            overflow_q  <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            s1_data_q   <= adc_in;
            s1_vld_q    <= (state_q == StRun) && en;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sync_q  <= out_sync_d;
            pend_sync_q <= pend_sync_d;
            overflow_q  <= overflow_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q]      <= wdata;
            sync_mem[wr_ptr_q] <= pend_sync_q;
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_sync  = out_sync_q;
    assign running          = (state_q == StRun);
    assign overflow         = overflow_q;
    assign overflow_cnt     = ovf_cnt_q;
endmodule
